// File: rtl/rob_commit_unit_pkg.sv
// Shared definitions for the reorder buffer: geometry, CDB lane layout and record types.
package rob_commit_unit_pkg;
   localparam int DEPTH  = 16;
   localparam int TAG_W  = 4;
   localparam int DATA_W = 16;
   localparam int REG_W  = 4;

   localparam int CDB_LANE_W  = 21;
   localparam int CDB_VALID   = 20;
   localparam int CDB_TAG_HI  = 19;
   localparam int CDB_TAG_LO  = 16;
   localparam int CDB_DATA_HI = 15;

   localparam logic [TAG_W-1:0] TAG_ONE   = TAG_W'(1'b1);
   localparam logic [TAG_W:0]   CNT_FULL  = (TAG_W+1)'(DEPTH);
   localparam logic [TAG_W:0]   ALLOC_MAX = (TAG_W+1)'(DEPTH - 2);

   typedef struct packed {
      logic              valid;
      logic              done;
      logic              wr;
      logic [REG_W-1:0]  areg;
      logic [DATA_W-1:0] data;
   } rob_entry_t;

   typedef struct packed {
      logic              valid;
      logic              wr;
      logic [TAG_W-1:0]  tag;
      logic [REG_W-1:0]  areg;
      logic [DATA_W-1:0] data;
   } commit_t;

   localparam rob_entry_t ENTRY_RESET  = '0;
   localparam commit_t    COMMIT_RESET = '0;
endpackage

// File: rtl/rob_commit_unit_cdb_lane_decode.sv
// Turns one CDB lane into a one-hot entry write-enable; an optional masking tag
// lets the higher-priority lane suppress this one when both name the same entry.
module cdb_lane_decode
   import rob_commit_unit_pkg::*;
(
   input  logic [CDB_LANE_W-1:0] lane,
   input  logic                  mask_en,
   input  logic [TAG_W-1:0]      mask_tag,
   output logic [DEPTH-1:0]      we,
   output logic [DATA_W-1:0]     data
);
   logic [TAG_W-1:0] tag_s;

   assign tag_s = lane[CDB_TAG_HI:CDB_TAG_LO];
   assign data  = lane[CDB_DATA_HI:0];

   // One-hot decode of the lane tag, dropped when the other lane owns this entry
   always_comb begin
      we = '0;
      if (lane[CDB_VALID] && !(mask_en && (mask_tag == tag_s))) begin
         we[tag_s] = 1'b1;
      end else begin
         we = '0;
      end
   end
endmodule

// File: rtl/rob_commit_unit.sv
// Reorder buffer: in-order dual allocation, CDB result capture by tag,
// and in-order dual retirement with registered commit outputs.
module rob_commit_unit
   import rob_commit_unit_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    alloc_req1,
   input  logic                    alloc_req2,
   input  logic [REG_W-1:0]        alloc_reg1,
   input  logic [REG_W-1:0]        alloc_reg2,
   input  logic                    alloc_wr1,
   input  logic                    alloc_wr2,
   output logic [TAG_W-1:0]        alloc_tag1,
   output logic [TAG_W-1:0]        alloc_tag2,
   output logic                    alloc_ok,
   input  logic [2*CDB_LANE_W-1:0] cdb_data,
   input  logic                    flush,
   output logic                    commit1_valid,
   output logic                    commit2_valid,
   output logic [REG_W-1:0]        commit1_reg,
   output logic [REG_W-1:0]        commit2_reg,
   output logic                    commit1_wr,
   output logic                    commit2_wr,
   output logic [DATA_W-1:0]       commit1_data,
   output logic [DATA_W-1:0]       commit2_data,
   output logic [TAG_W-1:0]        commit1_tag,
   output logic [TAG_W-1:0]        commit2_tag,
   output logic [TAG_W:0]          count,
   output logic                    empty,
   output logic                    full
);
   rob_entry_t        ent_q [DEPTH];
   rob_entry_t        ent_d [DEPTH];
   commit_t           cm1_q, cm1_d, cm2_q, cm2_d;
   logic [TAG_W-1:0]  head_q, head_d, tail_q, tail_d, head1_s;
   logic [TAG_W:0]    count_q, count_d;
   logic [DEPTH-1:0]  we0_s, we1_s;
   logic [DATA_W-1:0] lane0_data_s, lane1_data_s;
   logic              ret1_s, ret2_s, do1_s, do2_s;
   logic [1:0]        alloc_n_s, ret_n_s;

   cdb_lane_decode u_lane0 (
      .lane     (cdb_data[CDB_LANE_W-1:0]),
      .mask_en  (1'b0),
      .mask_tag ({TAG_W{1'b0}}),
      .we       (we0_s),
      .data     (lane0_data_s)
   );

   cdb_lane_decode u_lane1 (
      .lane     (cdb_data[2*CDB_LANE_W-1:CDB_LANE_W]),
      .mask_en  (cdb_data[CDB_VALID]),
      .mask_tag (cdb_data[CDB_TAG_HI:CDB_TAG_LO]),
      .we       (we1_s),
      .data     (lane1_data_s)
   );

   assign alloc_ok   = (count_q <= ALLOC_MAX);
   assign alloc_tag1 = tail_q;
   assign alloc_tag2 = tail_q + TAG_ONE;
   assign count      = count_q;
   assign empty      = (count_q == {(TAG_W+1){1'b0}});
   assign full       = (count_q == CNT_FULL);

   assign commit1_valid = cm1_q.valid;
   assign commit1_wr    = cm1_q.wr;
   assign commit1_tag   = cm1_q.tag;
   assign commit1_reg   = cm1_q.areg;
   assign commit1_data  = cm1_q.data;
   assign commit2_valid = cm2_q.valid;
   assign commit2_wr    = cm2_q.wr;
   assign commit2_tag   = cm2_q.tag;
   assign commit2_reg   = cm2_q.areg;
   assign commit2_data  = cm2_q.data;

   // Retire and allocate decisions; the second slot depends on the first
   always_comb begin
      head1_s   = head_q + TAG_ONE;
      ret1_s    = ent_q[head_q].valid & ent_q[head_q].done;
      ret2_s    = ret1_s & ent_q[head1_s].valid & ent_q[head1_s].done;
      do1_s     = alloc_ok & alloc_req1;
      do2_s     = do1_s & alloc_req2;
      alloc_n_s = {do2_s, do1_s & ~do2_s};
      ret_n_s   = {ret2_s, ret1_s & ~ret2_s};
   end

   // Next state of entries, pointers and commit registers; flush overrides everything
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         ent_d[i] = ent_q[i];
         if (flush) begin
            ent_d[i] = ENTRY_RESET;
         end else if ((ret1_s && (TAG_W'(i) == head_q)) || (ret2_s && (TAG_W'(i) == head1_s))) begin
            ent_d[i] = ENTRY_RESET;
         end else if (do1_s && (TAG_W'(i) == tail_q)) begin
            ent_d[i] = '{valid: 1'b1, done: 1'b0, wr: alloc_wr1, areg: alloc_reg1, data: {DATA_W{1'b0}}};
         end else if (do2_s && (TAG_W'(i) == alloc_tag2)) begin
            ent_d[i] = '{valid: 1'b1, done: 1'b0, wr: alloc_wr2, areg: alloc_reg2, data: {DATA_W{1'b0}}};
         end else if (ent_q[i].valid && !ent_q[i].done && we0_s[i]) begin
            ent_d[i].done = 1'b1;
            ent_d[i].data = lane0_data_s;
         end else if (ent_q[i].valid && !ent_q[i].done && we1_s[i]) begin
            ent_d[i].done = 1'b1;
            ent_d[i].data = lane1_data_s;
         end else begin
            ent_d[i] = ent_q[i];
         end
      end

      cm1_d       = cm1_q;
      cm1_d.valid = 1'b0;
      cm2_d       = cm2_q;
      cm2_d.valid = 1'b0;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         head_d  = head_q + TAG_W'(ret_n_s);
         tail_d  = tail_q + TAG_W'(alloc_n_s);
         count_d = count_q + (TAG_W+1)'(alloc_n_s) - (TAG_W+1)'(ret_n_s);
         if (ret1_s) begin
            cm1_d = '{valid: 1'b1, wr: ent_q[head_q].wr, tag: head_q,
                      areg: ent_q[head_q].areg, data: ent_q[head_q].data};
         end else begin
            cm1_d.valid = 1'b0;
         end
         if (ret2_s) begin
            cm2_d = '{valid: 1'b1, wr: ent_q[head1_s].wr, tag: head1_s,
                      areg: ent_q[head1_s].areg, data: ent_q[head1_s].data};
         end else begin
            cm2_d.valid = 1'b0;
         end
      end
   end

   // State registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= ENTRY_RESET;
         end
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         cm1_q   <= COMMIT_RESET;
         cm2_q   <= COMMIT_RESET;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= ent_d[i];
         end
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         cm1_q   <= cm1_d;
         cm2_q   <= cm2_d;
      end
   end
endmodule

// File: doc/rob_commit_unit.md
Name: rob_commit_unit

Overview:
- Reorder buffer that consumes the two-lane common data bus (CDB) driven by the execute buffer. It is the receiving end of that bus.
- Allocates in-order entries for up to two dispatched instructions per cycle and hands their tags to the dispatch buffer as robDest.
- Captures CDB results by tag.
- Retires up to two completed entries per cycle, in program order, toward the register file.

Parameters:
- DEPTH, 16, number of ROB entries (power of two).
- TAG_W, 4, tag width, log2(DEPTH).
- DATA_W, 16, result width.
- REG_W, 4, architectural register index width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- alloc_req1  in  1  dispatch slot 1 requests an entry.
- alloc_req2  in  1  dispatch slot 2 requests an entry; honoured only together with alloc_req1.
- alloc_reg1, alloc_reg2  in  REG_W  destination architectural register.
- alloc_wr1, alloc_wr2  in  1  instruction writes a register (0 for stores and branches).
- alloc_tag1, alloc_tag2  out  TAG_W  tags for slots 1 and 2; combinational, equal to tail and tail+1.
- alloc_ok  out  1  at least 2 free entries (combinational).
- cdb_data  in  42  two lanes: [20:0] lane0, [41:21] lane1. Each lane is {valid[20], tag[19:16], data[15:0]}.
- flush  in  1  synchronous squash of all entries (mispredict).
- commit1_valid, commit2_valid  out  1  registered retire pulses.
- commit1_reg, commit2_reg  out  REG_W  retired destination register.
- commit1_wr, commit2_wr  out  1  retired entry writes the register file.
- commit1_data, commit2_data  out  DATA_W  retired result.
- commit1_tag, commit2_tag  out  TAG_W  retired tag.
- count  out  TAG_W+1  occupied entries.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.

Behaviour:
- Reset (async): head=0, tail=0, count=0; every entry valid=0, done=0. All commit outputs 0; alloc_tag1=0, alloc_tag2=1.
- Entry state: valid, done, reg, wr, data.
- Allocation, at posedge when alloc_ok=1 and flush=0:
  - alloc_req1 alone: entry[tail] gets valid=1, done=0, reg/wr from slot 1; tail+=1.
  - alloc_req1 and alloc_req2: entries tail and tail+1 are written; tail+=2.
  - alloc_req2 without alloc_req1 is ignored.
  - If alloc_ok=0, all requests are dropped. Dispatch must stall; no partial allocation.
- Pointer arithmetic is modulo DEPTH (wrap 15→0).
- CDB capture, per lane with valid=1:
  - If entry[tag].valid=1 and done=0, set done=1 and data=lane data.
  - A write to an invalid or already-done entry is ignored.
  - Both lanes carrying the same tag: lane0 wins.
- Commit, at posedge:
  - If entry[head].valid and done, retire it into the commit1 outputs.
  - If that happens and entry[head+1].valid and done, also retire head+1 into the commit2 outputs.
  - Retired entries are cleared (valid=0, done=0); head advances by the number retired.
  - Commit outputs are registered, 1-cycle latency from the done state. The valid pulses last one cycle; data holds its last value when valid=0.
- No CDB bypass: an entry written by the CDB in cycle N is eligible to commit at the edge ending cycle N+1.
- Same-cycle events: count_next = count + allocated − retired. alloc_ok is computed from the current count, so retirement does not free space for allocation in the same cycle.
- Full/empty:
  - alloc_ok=0 when count>DEPTH−2.
  - Commit on empty produces no pulses.
  - head==tail is disambiguated by count.
- Flush, synchronous, highest priority:
  - Clears all valid/done bits; head=tail=0, count=0.
  - Commit valids are 0 on the following cycle.
  - Allocation, CDB capture and commit in the flush cycle are discarded.
- Reset asserted mid-operation returns every state bit to the reset values immediately.

Decomposition:
- Shared package holds:
  - CDB lane field positions: CDB_VALID=20, CDB_TAG_HI=19, CDB_TAG_LO=16, CDB_DATA_HI=15, lane width 21.
  - TAG_W, DATA_W, REG_W.
  - An entry record type {valid, done, wr, reg, data}.
- Sub-module cdb_lane_decode, instantiated twice: decodes one 21-bit lane into a DEPTH-bit one-hot write-enable vector plus data. Lane0 masks lane1 on a tag match.

Test Plan:
- Reset then idle: count=0, empty=1, alloc_tag1=0, alloc_tag2=1, alloc_ok=1, no commit pulses.
- Dual alloc (reg 3, reg 5) → tags 0,1. Then CDB lane0 {1,tag1,0x00BB} and lane1 {1,tag0,0x00AA} in the same cycle → next edge commit1 = tag0/reg3/0x00AA and commit2 = tag1/reg5/0x00BB; count 2→0.
- Out-of-order completion: allocate 0,1,2; CDB writes tag2, then tag1 → no commits. Then CDB writes tag0 → commit1=tag0 and commit2=tag1 next edge, then commit1=tag2 the edge after.
- Fill to 15 entries → alloc_ok=0; request dropped, tail unchanged. Retire one → alloc_ok=1; dual alloc wraps tags to 15 and 0.
- Both lanes carry tag 4 with 0x1111 (lane0) and 0x2222 (lane1) → entry 4 commits 0x1111.
- Flush asserted with pending alloc, a CDB write and a committable head → next cycle count=0, no commit pulses, alloc_tag1=0.
